// File: rtl/serial_kbd_receiver.sv
// 8N1 serial receiver with a small byte FIFO, delivered one byte per interrupt
// through the irq/iack/iend handshake.
module serial_kbd_receiver #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       IN_PB_RESET,
  input  logic       IN_SERIAL_RX,
  output logic [7:0] kbd,
  output logic       irq,
  input  logic       iack,
  input  logic       iend,
  output logic       overflow,
  output logic       frame_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {I_IDLE, I_REQ, I_SERV} irq_state_e;

  rx_state_e  rx_state_q;
  irq_state_e irq_state_q;
  logic          sync1_q, rxs_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    data_q;
  logic [7:0]    kbd_q;
  logic          irq_q, overflow_q, frame_error_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push_w, pop_w, push_ok;

  // Sync flops preset to 1 so reset never looks like a start bit.
  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= IN_SERIAL_RX;
      rxs_q   <= sync1_q;
    end
  end

  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      rx_state_q    <= RX_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      data_q        <= '0;
      frame_error_q <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!rxs_q) begin
            rx_state_q <= RX_START;
            cnt_q      <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HALF_TC) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            rx_state_q <= rxs_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL_TC) begin
            data_q[bit_idx_q] <= rxs_q;
            cnt_q             <= '0;
            if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
            else                   bit_idx_q  <= bit_idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == FULL_TC) begin
            if (!rxs_q) frame_error_q <= 1'b1;
            rx_state_q <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign push_w  = (rx_state_q == RX_STOP) && (cnt_q == FULL_TC) && rxs_q;
  assign pop_w   = (irq_state_q == I_REQ) && iack;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push_w && ((count_q != DEPTH_C) || pop_w);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_w})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_q;
  end

  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_ok)           wr_ptr_q   <= wr_ptr_q + AW'(1);
      if (pop_w)             rd_ptr_q   <= rd_ptr_q + AW'(1);
      if (push_w && !push_ok) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      irq_state_q <= I_IDLE;
      irq_q       <= 1'b0;
      kbd_q       <= '0;
    end else begin
      case (irq_state_q)
        I_IDLE: begin
          if (count_q != '0) begin
            irq_state_q <= I_REQ;
            irq_q       <= 1'b1;
          end
        end
        I_REQ: begin
          if (iack) begin
            kbd_q       <= mem_q[rd_ptr_q];
            irq_q       <= 1'b0;
            irq_state_q <= I_SERV;
          end
        end
        I_SERV: begin
          if (iend) irq_state_q <= I_IDLE;
        end
        default: begin
          irq_state_q <= I_IDLE;
          irq_q       <= 1'b0;
        end
      endcase
    end
  end

  assign kbd         = kbd_q;
  assign irq         = irq_q;
  assign overflow    = overflow_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_serial_kbd_receiver.sv
// Directed bench for serial_kbd_receiver with a byte scoreboard queue.
module tb_serial_kbd_receiver;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       IN_PB_RESET;
  logic       IN_SERIAL_RX;
  logic [7:0] kbd;
  logic       irq;
  logic       iack;
  logic       iend;
  logic       overflow;
  logic       frame_error;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic       m_ovf  = 1'b0;
  logic       m_ferr = 1'b0;

  serial_kbd_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK),
    .IN_PB_RESET(IN_PB_RESET),
    .IN_SERIAL_RX(IN_SERIAL_RX),
    .kbd(kbd),
    .irq(irq),
    .iack(iack),
    .iend(iend),
    .overflow(overflow),
    .frame_error(frame_error)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_head(input logic [7:0] b);
    IN_SERIAL_RX = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      IN_SERIAL_RX = b[i];
      repeat (CPB) tick();
    end
  endtask

  task automatic send_stop(input logic v);
    IN_SERIAL_RX = v;
    repeat (CPB) tick();
    IN_SERIAL_RX = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    send_head(b);
    send_stop(stop_ok);
    if (!stop_ok)                 m_ferr = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                           m_ovf = 1'b1;
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (irq !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk(tag, irq, 1);
  endtask

  task automatic service(input string tag);
    logic [7:0] e;
    wait_irq({tag, "_irq"});
    iack = 1'b1;
    tick();
    iack = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=%0h expected=empty_queue", tag, kbd);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_kbd"}, kbd, e);
    end
    chk({tag, "_irq_low"}, irq, 0);
    iend = 1'b1;
    tick();
    iend = 1'b0;
  endtask

  initial begin
    IN_PB_RESET  = 1'b0;
    IN_SERIAL_RX = 1'b1;
    iack = 1'b0;
    iend = 1'b0;
    for (int i = 0; i < 6; i++) begin
      IN_SERIAL_RX = ~IN_SERIAL_RX;
      tick();
    end
    chk("rst_kbd", kbd, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_error, 0);
    IN_SERIAL_RX = 1'b1;
    IN_PB_RESET  = 1'b1;
    repeat (20) tick();
    chk("idle_irq", irq, 0);

    // Single byte with end-to-end latency check on the stop bit
    send_head(8'hA5);
    IN_SERIAL_RX = 1'b1;
    repeat (13) tick();
    chk("lat_irq", irq, 1);
    repeat (3) tick();
    exp_q.push_back(8'hA5);
    service("a5");
    repeat (4) tick();
    chk("a5_after_iend", irq, 0);

    // Short low pulse must be rejected as a glitch
    IN_SERIAL_RX = 1'b0;
    repeat (5) tick();
    IN_SERIAL_RX = 1'b1;
    repeat (20) tick();
    chk("glitch_irq", irq, 0);
    send_byte(8'h3C, 1'b1);
    service("3c");

    // Fill the FIFO and overflow it
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    chk("ovf_flag", overflow, m_ovf);
    for (int i = 0; i < 4; i++) service("q");
    repeat (6) tick();
    chk("q_drained_irq", irq, exp_q.size() != 0);

    // Framing error
    send_byte(8'h7E, 1'b0);
    repeat (20) tick();
    chk("ferr_flag", frame_error, m_ferr);
    chk("ferr_irq", irq, 0);
    send_byte(8'h11, 1'b1);
    service("11");

    // Handshake misuse: iack+iend together, then iack during service
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    wait_irq("mis_irq");
    iack = 1'b1;
    iend = 1'b1;
    tick();
    iack = 1'b0;
    iend = 1'b0;
    chk("mis_kbd", kbd, exp_q.pop_front());
    tick();
    iack = 1'b1;
    tick();
    iack = 1'b0;
    chk("mis_kbd_hold", kbd, 8'h66);
    repeat (3) tick();
    chk("mis_serv_irq", irq, 0);
    iend = 1'b1;
    tick();
    iend = 1'b0;
    service("77");

    // Async reset in the middle of data bit 4
    IN_SERIAL_RX = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      IN_SERIAL_RX = i[0];
      repeat (CPB) tick();
    end
    IN_SERIAL_RX = 1'b1;
    repeat (CPB / 2) tick();
    IN_PB_RESET = 1'b0;
    #1;
    chk("arst_kbd", kbd, 0);
    chk("arst_irq", irq, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_ferr", frame_error, 0);
    exp_q.delete();
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    repeat (4) begin
      IN_SERIAL_RX = ~IN_SERIAL_RX;
      tick();
    end
    IN_SERIAL_RX = 1'b1;
    IN_PB_RESET  = 1'b1;
    repeat (20) tick();
    chk("arst_idle_irq", irq, 0);
    send_byte(8'h5A, 1'b1);
    service("5a");
    repeat (6) tick();
    chk("end_irq", irq, exp_q.size() != 0);
    chk("end_ovf", overflow, m_ovf);
    chk("end_ferr", frame_error, m_ferr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
